// File: rtl/load_issue_scheduler_if.sv
// Memory read-port handshake between the load issue scheduler (master) and the data memory (slave).
interface load_issue_scheduler_if #(
   parameter int IDX_W = 3
);
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic [IDX_W-1:0] mem_req_idx;
   logic             mem_resp_valid;

   modport master (
      output mem_req_valid,
      output mem_req_idx,
      input  mem_req_ready,
      input  mem_resp_valid
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_idx,
      output mem_req_ready,
      output mem_resp_valid
   );
endinterface

// File: rtl/load_issue_scheduler.sv
// Issues the oldest ready load (age measured from the queue head) to a single memory read port, one in flight.
// Optional feature: define LIS_PERF_CNT_EN to add handshake and stall performance counters.
module load_issue_scheduler #(
   parameter int LDQ_SIZE = 8,
   parameter int IDX_W    = $clog2(LDQ_SIZE)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_W-1:0]    head,
   input  logic [LDQ_SIZE-1:0] entry_valid,
   input  logic [LDQ_SIZE-1:0] entry_ready,
   input  logic                flush,
   load_issue_scheduler_if.master mem,
   output logic                done_valid,
   output logic [IDX_W-1:0]    done_idx,
   output logic                busy
`ifdef LIS_PERF_CNT_EN
   ,
   output logic [31:0]         perf_issue_cnt,
   output logic [31:0]         perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    reqIdx_q, reqIdx_d;
   logic [LDQ_SIZE-1:0] issued_q, issued_d;

   logic [LDQ_SIZE-1:0] cand;
   logic                selFound;
   logic [IDX_W-1:0]    selIdx;
   logic [IDX_W-1:0]    probe;
   logic                handshake;

   assign cand = entry_valid & entry_ready & ~issued_q;

   // Walk from the youngest age down to age 0 so the last hit is the oldest candidate.
   always_comb begin
      selFound = 1'b0;
      selIdx   = '0;
      probe    = '0;
      for (int k = LDQ_SIZE - 1; k >= 0; k--) begin
         probe = head + IDX_W'(k);
         if (cand[probe]) begin
            selFound = 1'b1;
            selIdx   = probe;
         end
      end
   end

   always_comb begin
      state_d           = state_q;
      reqIdx_d          = reqIdx_q;
      handshake         = 1'b0;
      done_valid        = 1'b0;
      mem.mem_req_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (selFound && !flush) begin
               reqIdx_d = selIdx;
               state_d  = REQ;
            end
         end
         REQ: begin
            mem.mem_req_valid = 1'b1;
            if (mem.mem_req_ready) begin
               handshake = 1'b1;
               state_d   = flush ? DRAIN : WAIT;
            end else if (flush || !entry_valid[reqIdx_q]) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (mem.mem_resp_valid) begin
               done_valid = !flush;
               state_d    = IDLE;
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem.mem_resp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem.mem_req_idx = (state_q == REQ) ? reqIdx_q : '0;
   assign done_idx        = done_valid ? reqIdx_q : '0;
   assign busy            = (state_q != IDLE);

   // Flush wins over a same-cycle handshake so the queue sees every entry as re-issuable.
   always_comb begin
      issued_d = issued_q;
      if (handshake) begin
         issued_d[reqIdx_q] = 1'b1;
      end
      issued_d = issued_d & entry_valid;
      if (flush) begin
         issued_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         reqIdx_q <= '0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         reqIdx_q <= reqIdx_d;
         issued_q <= issued_d;
      end
   end

`ifdef LIS_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (handshake) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         end
         if (state_q == REQ && !mem.mem_req_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_load_issue_scheduler.sv
// Self-checking bench for load_issue_scheduler: directed scenarios plus a randomized run against a transaction-level model.
module tb_load_issue_scheduler;

   logic       clk;
   logic       reset;
   logic [2:0] head;
   logic [7:0] entryValid;
   logic [7:0] entryReady;
   logic       flush;
   logic       doneValid;
   logic [2:0] doneIdx;
   logic       busy;
`ifdef LIS_PERF_CNT_EN
   logic [31:0] perfIssue;
   logic [31:0] perfStall;
`endif

   int errors;
   int checks;

   load_issue_scheduler_if #(.IDX_W(3)) memIf ();

   load_issue_scheduler #(.LDQ_SIZE(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .head        (head),
      .entry_valid (entryValid),
      .entry_ready (entryReady),
      .flush       (flush),
      .mem         (memIf.master),
      .done_valid  (doneValid),
      .done_idx    (doneIdx),
      .busy        (busy)
`ifdef LIS_PERF_CNT_EN
      ,
      .perf_issue_cnt (perfIssue),
      .perf_stall_cnt (perfStall)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset;
      reset = 1'b1;
      head = '0; entryValid = '0; entryReady = '0; flush = 1'b0;
      memIf.mem_req_ready = 1'b0; memIf.mem_resp_valid = 1'b0;
      tick;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      doReset;
      checks++;
      if ({memIf.mem_req_valid, memIf.mem_req_idx, doneValid, doneIdx, busy} !== 9'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b required 0", {memIf.mem_req_valid, memIf.mem_req_idx, doneValid, doneIdx, busy});
      end
   endtask

   task automatic test_wrap_age;
      doReset;
      head = 3'd6; entryValid = 8'b1000_0010; entryReady = 8'b1000_0010;
      #1;
      checks++;
      if (memIf.mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_latency: valid=%b required 0", memIf.mem_req_valid); end
      tick;
      checks++;
      if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_idx !== 3'd7) begin
         errors++; $display("[TB] FAIL wrap_first: valid=%b idx=%0d required 1/7", memIf.mem_req_valid, memIf.mem_req_idx);
      end
      memIf.mem_req_ready = 1'b1;
      tick;
      memIf.mem_req_ready = 1'b0; memIf.mem_resp_valid = 1'b1;
      #1;
      checks++;
      if (doneValid !== 1'b1 || doneIdx !== 3'd7) begin
         errors++; $display("[TB] FAIL wrap_done7: done=%b idx=%0d required 1/7", doneValid, doneIdx);
      end
      tick;
      memIf.mem_resp_valid = 1'b0; entryValid = 8'b0000_0010; entryReady = 8'b0000_0010;
      tick;
      checks++;
      if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_idx !== 3'd1) begin
         errors++; $display("[TB] FAIL wrap_second: valid=%b idx=%0d required 1/1", memIf.mem_req_valid, memIf.mem_req_idx);
      end
   endtask

   task automatic test_backpressure;
      doReset;
      entryValid = 8'b0000_1000; entryReady = 8'b0000_1000;
      tick;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_idx !== 3'd3) begin
            errors++; $display("[TB] FAIL backpressure_hold[%0d]: valid=%b idx=%0d required 1/3", c, memIf.mem_req_valid, memIf.mem_req_idx);
         end
         tick;
      end
`ifdef LIS_PERF_CNT_EN
      checks++;
      if (perfStall !== 32'd5) begin errors++; $display("[TB] FAIL perf_stall: got %0d required 5", perfStall); end
`endif
      memIf.mem_req_ready = 1'b1;
      tick;
      memIf.mem_req_ready = 1'b0;
      checks++;
      if (memIf.mem_req_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL backpressure_accept: valid=%b busy=%b required 0/1", memIf.mem_req_valid, busy);
      end
`ifdef LIS_PERF_CNT_EN
      checks++;
      if (perfIssue !== 32'd1) begin errors++; $display("[TB] FAIL perf_issue: got %0d required 1", perfIssue); end
`endif
   endtask

   task automatic test_full_path;
      int pulses;
      doReset;
      pulses = 0;
      entryValid = 8'b0000_0100; entryReady = 8'b0000_0100;
      tick;
      memIf.mem_req_ready = 1'b1;
      tick;
      memIf.mem_req_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         memIf.mem_resp_valid = (c == 3);
         #1;
         if (doneValid === 1'b1) begin
            pulses++;
            checks++;
            if (doneIdx !== 3'd2) begin errors++; $display("[TB] FAIL full_done_idx: got %0d required 2", doneIdx); end
         end
         tick;
      end
      memIf.mem_resp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (doneValid === 1'b1) pulses++;
         tick;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("[TB] FAIL full_pulses: got %0d required 1", pulses); end
      checks++;
      if (memIf.mem_req_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL full_issued_held: valid=%b busy=%b required 0/0", memIf.mem_req_valid, busy);
      end
      entryValid = 8'b0000_0000;
      tick;
      entryValid = 8'b0000_0100;
      tick;
      checks++;
      if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_idx !== 3'd2) begin
         errors++; $display("[TB] FAIL full_realloc: valid=%b idx=%0d required 1/2", memIf.mem_req_valid, memIf.mem_req_idx);
      end
      entryValid = 8'b0000_0000;
      tick;
      checks++;
      if (memIf.mem_req_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL full_abandon: valid=%b busy=%b required 0/0", memIf.mem_req_valid, busy);
      end
   endtask

   task automatic test_flush_wait;
      int pulses;
      doReset;
      pulses = 0;
      entryValid = 8'b0010_0000; entryReady = 8'b0010_0000;
      tick;
      memIf.mem_req_ready = 1'b1;
      tick;
      memIf.mem_req_ready = 1'b0; flush = 1'b1; entryValid = 8'b0000_0000;
      tick;
      flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         memIf.mem_resp_valid = (c == 2);
         #1;
         if (doneValid !== 1'b0) pulses++;
         checks++;
         if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flushwait_busy[%0d]: got %b required 1", c, busy); end
         tick;
      end
      memIf.mem_resp_valid = 1'b0;
      checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL flushwait_drain: pulses=%0d busy=%b required 0/0", pulses, busy);
      end
      entryValid = 8'b0010_0000;
      tick;
      checks++;
      if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_idx !== 3'd5) begin
         errors++; $display("[TB] FAIL flushwait_reissue: valid=%b idx=%0d required 1/5", memIf.mem_req_valid, memIf.mem_req_idx);
      end
   endtask

   task automatic test_flush_handshake;
      doReset;
      entryValid = 8'b0001_0000; entryReady = 8'b0001_0000;
      tick;
      memIf.mem_req_ready = 1'b1; flush = 1'b1;
      tick;
      memIf.mem_req_ready = 1'b0; flush = 1'b0;
      checks++;
      if (memIf.mem_req_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL flushhs_drain: valid=%b busy=%b required 0/1", memIf.mem_req_valid, busy);
      end
      memIf.mem_resp_valid = 1'b1;
      #1;
      checks++;
      if (doneValid !== 1'b0) begin errors++; $display("[TB] FAIL flushhs_discard: done=%b required 0", doneValid); end
      tick;
      memIf.mem_resp_valid = 1'b0;
      tick;
      checks++;
      if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_idx !== 3'd4) begin
         errors++; $display("[TB] FAIL flushhs_issued_clear: valid=%b idx=%0d required 1/4", memIf.mem_req_valid, memIf.mem_req_idx);
      end
`ifdef LIS_PERF_CNT_EN
      checks++;
      if (perfIssue !== 32'd1) begin errors++; $display("[TB] FAIL flushhs_perf: got %0d required 1", perfIssue); end
`endif
   endtask

   task automatic test_reset_mid;
      doReset;
      entryValid = 8'b0000_0001; entryReady = 8'b0000_0001;
      tick;
      memIf.mem_req_ready = 1'b1;
      tick;
      memIf.mem_req_ready = 1'b0; memIf.mem_resp_valid = 1'b1; reset = 1'b1;
      #1;
      checks++;
      if ({memIf.mem_req_valid, memIf.mem_req_idx, doneValid, doneIdx, busy} !== 9'd0) begin
         errors++; $display("[TB] FAIL resetmid_outputs: got %b required 0", {memIf.mem_req_valid, memIf.mem_req_idx, doneValid, doneIdx, busy});
      end
      tick;
      reset = 1'b0; memIf.mem_resp_valid = 1'b0; entryValid = '0; entryReady = '0;
      for (int c = 0; c < 3; c++) begin
         tick;
         checks++;
         if (memIf.mem_req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL resetmid_idle[%0d]: valid=%b busy=%b required 0/0", c, memIf.mem_req_valid, busy);
         end
      end
   endtask

   task automatic test_random;
      bit         hasReq, outst, discard, hs;
      logic [2:0] rIdx;
      logic [7:0] iss;
      int         memLat, best, bestAge, age;
      int unsigned mIssue, mStall;
      logic       expValid, expDone;
      logic [2:0] expIdx, expDoneIdx;
      logic       expBusy;
      doReset;
      hasReq = 0; outst = 0; discard = 0; rIdx = '0; iss = '0; memLat = 0; mIssue = 0; mStall = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 15) == 0) head = 3'($urandom);
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 7) == 0) entryValid[i] = ~entryValid[i];
         end
         entryReady = 8'($urandom);
         flush = ($urandom_range(0, 19) == 0);
         memIf.mem_req_ready = ($urandom_range(0, 2) != 0);
         memIf.mem_resp_valid = outst && (memLat == 0);
         #1;
         expValid   = hasReq;
         expIdx     = hasReq ? rIdx : 3'd0;
         expBusy    = hasReq || outst;
         expDone    = outst && !discard && memIf.mem_resp_valid && !flush;
         expDoneIdx = expDone ? rIdx : 3'd0;
         checks++;
         if (memIf.mem_req_valid !== expValid || memIf.mem_req_idx !== expIdx) begin
            errors++; $display("[TB] FAIL rand_req c%0d: valid=%b idx=%0d required %b/%0d", cyc, memIf.mem_req_valid, memIf.mem_req_idx, expValid, expIdx);
         end
         checks++;
         if (doneValid !== expDone || doneIdx !== expDoneIdx) begin
            errors++; $display("[TB] FAIL rand_done c%0d: done=%b idx=%0d required %b/%0d", cyc, doneValid, doneIdx, expDone, expDoneIdx);
         end
         checks++;
         if (busy !== expBusy) begin
            errors++; $display("[TB] FAIL rand_busy c%0d: got %b required %b", cyc, busy, expBusy);
         end
         // Advance the reference model across the coming clock edge.
         hs = hasReq && memIf.mem_req_ready;
         if (hasReq && !memIf.mem_req_ready) mStall++;
         best = -1; bestAge = 99;
         for (int i = 0; i < 8; i++) begin
            age = (i - int'(head) + 8) % 8;
            if (entryValid[i] && entryReady[i] && !iss[i] && age < bestAge) begin
               best = i; bestAge = age;
            end
         end
         if (hasReq) begin
            if (hs) begin
               hasReq = 0; outst = 1; discard = flush; iss[rIdx] = 1'b1; mIssue++;
               memLat = $urandom_range(0, 4);
            end else if (flush || !entryValid[rIdx]) begin
               hasReq = 0;
            end
         end else if (outst) begin
            if (memIf.mem_resp_valid) begin
               outst = 0; discard = 0;
            end else begin
               if (flush) discard = 1;
               if (memLat > 0) memLat--;
            end
         end else if (!flush && best >= 0) begin
            hasReq = 1; rIdx = 3'(best);
         end
         iss = iss & entryValid;
         if (flush) iss = '0;
         tick;
      end
`ifdef LIS_PERF_CNT_EN
      checks++;
      if (perfIssue !== mIssue || perfStall !== mStall) begin
         errors++; $display("[TB] FAIL rand_perf: issue=%0d stall=%0d required %0d/%0d", perfIssue, perfStall, mIssue, mStall);
      end
`endif
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset;
      test_wrap_age;
      test_backpressure;
      test_full_path;
      test_flush_wait;
      test_flush_handshake;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
